// File: rtl/dmac_pkg.sv
// Shared encodings for the multi-channel DMAC register slave: engine states,
// register offsets, the global bank index and ERR bit positions.
package dmac_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_POP     = 3'd1;
  localparam logic [2:0] ST_REQUEST = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [3:0] OFF_CLEAR   = 4'h0;
  localparam logic [3:0] OFF_START   = 4'h1;
  localparam logic [3:0] OFF_INTR_EN = 4'h2;
  localparam logic [3:0] OFF_SRC     = 4'h3;
  localparam logic [3:0] OFF_DST     = 4'h4;
  localparam logic [3:0] OFF_PUSH    = 4'h5;
  localparam logic [3:0] OFF_DCNT    = 4'h6;
  localparam logic [3:0] OFF_SIZE    = 4'h7;
  localparam logic [3:0] OFF_OPMODE  = 4'h8;
  localparam logic [3:0] OFF_DONE    = 4'h9;

  localparam logic [3:0] OFF_IRQ_STAT = 4'h0;
  localparam logic [3:0] OFF_ERR      = 4'h1;

  localparam logic [3:0] GLOBAL_CH = 4'hF;

  localparam int ERR_UNMAPPED   = 0;
  localparam int ERR_PUSH_FULL  = 1;
  localparam int ERR_START_BUSY = 2;
  localparam int ERR_CFG_BUSY   = 3;
  localparam int ERR_W          = 4;

  // Engine is mid-transfer; configuration must stay frozen.
  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_POP) || (st == ST_REQUEST) || (st == ST_READ) || (st == ST_WRITE);
  endfunction

  function automatic logic is_cfg_off(input logic [3:0] off);
    return (off == OFF_INTR_EN) || (off == OFF_SRC) || (off == OFF_DST) ||
           (off == OFF_SIZE) || (off == OFF_OPMODE);
  endfunction

endpackage

// File: rtl/dmac_slave_ch.sv
// One channel's register bank: config registers, start/clear/push pulses,
// sticky done flag, per-channel irq and the channel's read mux.
module dmac_slave_ch
  import dmac_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DCNT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_i,
  input  logic [3:0]        off_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [2:0]        state_i,
  input  logic              op_done_i,
  input  logic              desc_full_i,
  input  logic [DCNT_W-1:0] data_count_i,
  output logic              op_start_o,
  output logic              op_clear_o,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] sc_addr_o,
  output logic [DATA_W-1:0] ds_addr_o,
  output logic [DATA_W-1:0] data_size_o,
  output logic [DATA_W-1:0] opmode_o,
  output logic              irq_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] mode_q, mode_d;
  logic              ien_q, ien_d;
  logic              done_q, done_d;
  logic              start_q, clear_q, push_q;

  logic busy;
  logic do_clear;
  logic do_start;
  logic do_push;

  assign busy     = is_busy(state_i);
  assign do_clear = wr_i && (off_i == OFF_CLEAR) && din_i[0] && done_q;
  assign do_start = wr_i && (off_i == OFF_START) && din_i[0] && (state_i == ST_IDLE);
  assign do_push  = wr_i && (off_i == OFF_PUSH) && din_i[0] && !desc_full_i;

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    size_d = size_q;
    mode_d = mode_q;
    ien_d  = ien_q;
    done_d = done_q | op_done_i;
    if (wr_i && !busy) begin
      case (off_i)
        OFF_INTR_EN: ien_d  = din_i[0];
        OFF_SRC:     src_d  = din_i;
        OFF_DST:     dst_d  = din_i;
        OFF_SIZE:    size_d = din_i;
        OFF_OPMODE:  mode_d = din_i;
        default: ;
      endcase
    end
    // Clear wipes the bank and beats a done arriving on the same edge.
    if (do_clear) begin
      src_d  = '0;
      dst_d  = '0;
      size_d = '0;
      mode_d = '0;
      ien_d  = 1'b0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      size_q  <= '0;
      mode_q  <= '0;
      ien_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      size_q  <= size_d;
      mode_q  <= mode_d;
      ien_q   <= ien_d;
      done_q  <= done_d;
      start_q <= do_start;
      clear_q <= do_clear;
      push_q  <= do_push;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      OFF_INTR_EN: rdata_o = DATA_W'(ien_q);
      OFF_SRC:     rdata_o = src_q;
      OFF_DST:     rdata_o = dst_q;
      OFF_DCNT:    rdata_o = DATA_W'(data_count_i);
      OFF_SIZE:    rdata_o = size_q;
      OFF_OPMODE:  rdata_o = mode_q;
      OFF_DONE:    rdata_o = DATA_W'(done_q);
      default: ;
    endcase
  end

  assign op_start_o  = start_q;
  assign op_clear_o  = clear_q;
  assign wr_en_o     = push_q;
  assign sc_addr_o   = src_q;
  assign ds_addr_o   = dst_q;
  assign data_size_o = size_q;
  assign opmode_o    = mode_q;
  assign irq_o       = ien_q & done_q;

endmodule

// File: rtl/dmac_slave_mc.sv
// Multi-channel DMAC register slave: channel decode, global IRQ/ERR bank and
// registered read data. Define DMAC_SLAVE_ERR_EN to build the sticky ERR register.
module dmac_slave_mc
  import dmac_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DCNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     S_sel,
  input  logic                     S_wr,
  input  logic [7:0]               S_address,
  input  logic [DATA_W-1:0]        S_din,
  output logic [DATA_W-1:0]        S_dout,
  input  logic [3*NUM_CH-1:0]      state,
  input  logic [NUM_CH-1:0]        op_done,
  input  logic [NUM_CH-1:0]        desc_full,
  input  logic [DCNT_W*NUM_CH-1:0] data_count,
  output logic [NUM_CH-1:0]        op_start,
  output logic [NUM_CH-1:0]        op_clear,
  output logic [NUM_CH-1:0]        wr_en,
  output logic [DATA_W*NUM_CH-1:0] sc_addr,
  output logic [DATA_W*NUM_CH-1:0] ds_addr,
  output logic [DATA_W*NUM_CH-1:0] data_size,
  output logic [DATA_W*NUM_CH-1:0] opmode,
  output logic                     Interrupt,
  output logic                     err_irq
);

  logic [3:0]        ch_idx;
  logic [3:0]        off;
  logic              wr_stb;
  logic              rd_stb;
  logic              ch_valid;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] irq_vec;
  logic [DATA_W-1:0] ch_rdata [NUM_CH];
  logic [DATA_W-1:0] glb_rdata;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] dout_q, dout_d;

  assign ch_idx   = S_address[7:4];
  assign off      = S_address[3:0];
  assign wr_stb   = S_sel & S_wr;
  assign rd_stb   = S_sel & ~S_wr;
  assign ch_valid = ch_idx < 4'(NUM_CH);

  always_comb begin
    ch_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr[i] = wr_stb && (ch_idx == 4'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dmac_slave_ch #(
      .DATA_W(DATA_W),
      .DCNT_W(DCNT_W)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_i         (ch_wr[g]),
      .off_i        (off),
      .din_i        (S_din),
      .state_i      (state[3*g +: 3]),
      .op_done_i    (op_done[g]),
      .desc_full_i  (desc_full[g]),
      .data_count_i (data_count[DCNT_W*g +: DCNT_W]),
      .op_start_o   (op_start[g]),
      .op_clear_o   (op_clear[g]),
      .wr_en_o      (wr_en[g]),
      .sc_addr_o    (sc_addr[DATA_W*g +: DATA_W]),
      .ds_addr_o    (ds_addr[DATA_W*g +: DATA_W]),
      .data_size_o  (data_size[DATA_W*g +: DATA_W]),
      .opmode_o     (opmode[DATA_W*g +: DATA_W]),
      .irq_o        (irq_vec[g]),
      .rdata_o      (ch_rdata[g])
    );
  end

  assign Interrupt = |irq_vec;

`ifdef DMAC_SLAVE_ERR_EN
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] err_set;
  logic [ERR_W-1:0] err_clr;

  always_comb begin
    err_set = '0;
    err_set[ERR_UNMAPPED] = S_sel && !ch_valid && (ch_idx != GLOBAL_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_wr[i]) begin
        if (S_din[0] && (off == OFF_START) && (state[3*i +: 3] != ST_IDLE))
          err_set[ERR_START_BUSY] = 1'b1;
        if (S_din[0] && (off == OFF_PUSH) && desc_full[i])
          err_set[ERR_PUSH_FULL] = 1'b1;
        if (is_cfg_off(off) && is_busy(state[3*i +: 3]))
          err_set[ERR_CFG_BUSY] = 1'b1;
      end
    end
    err_clr = '0;
    if (wr_stb && (ch_idx == GLOBAL_CH) && (off == OFF_ERR))
      err_clr = S_din[ERR_W-1:0];
    // A new error on the same edge as its W1C clear is kept.
    err_d = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err_irq = |err_q;
`else
  assign err_irq = 1'b0;
`endif

  always_comb begin
    glb_rdata = '0;
    case (off)
      OFF_IRQ_STAT: glb_rdata = DATA_W'(irq_vec);
`ifdef DMAC_SLAVE_ERR_EN
      OFF_ERR:      glb_rdata = DATA_W'(err_q);
`endif
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    if (ch_idx == GLOBAL_CH) begin
      rd_mux = glb_rdata;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == 4'(i)) rd_mux = ch_rdata[i];
      end
    end
  end

  assign dout_d = rd_stb ? rd_mux : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dout_q <= '0;
    else          dout_q <= dout_d;
  end

  assign S_dout = dout_q;

endmodule

// File: tb/tb_dmac_slave_mc.sv
// Bench for dmac_slave_mc: directed scenarios with literal expectations, then
// random bus traffic checked every cycle against a register-level model.
module tb_dmac_slave_mc;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DCNT_W = 4;
`ifdef DMAC_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     S_sel, S_wr;
  logic [7:0]               S_address;
  logic [DATA_W-1:0]        S_din, S_dout;
  logic [3*NUM_CH-1:0]      state;
  logic [NUM_CH-1:0]        op_done, desc_full;
  logic [DCNT_W*NUM_CH-1:0] data_count;
  logic [NUM_CH-1:0]        op_start, op_clear, wr_en;
  logic [DATA_W*NUM_CH-1:0] sc_addr, ds_addr, data_size, opmode;
  logic                     Interrupt, err_irq;

  always #5 clk = ~clk;

  dmac_slave_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DCNT_W(DCNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address),
    .S_din(S_din), .S_dout(S_dout), .state(state), .op_done(op_done),
    .desc_full(desc_full), .data_count(data_count), .op_start(op_start),
    .op_clear(op_clear), .wr_en(wr_en), .sc_addr(sc_addr), .ds_addr(ds_addr),
    .data_size(data_size), .opmode(opmode), .Interrupt(Interrupt), .err_irq(err_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_src [NUM_CH];
  logic [DATA_W-1:0] m_dst [NUM_CH];
  logic [DATA_W-1:0] m_size[NUM_CH];
  logic [DATA_W-1:0] m_mode[NUM_CH];
  logic [NUM_CH-1:0] m_ien, m_done, m_start, m_clear, m_push;
  logic [DATA_W-1:0] m_dout;
  logic [3:0]        m_err;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_size[c] = '0; m_mode[c] = '0;
    end
    m_ien = '0; m_done = '0; m_start = '0; m_clear = '0; m_push = '0;
    m_dout = '0; m_err = '0;
  endtask

  task automatic model_step();
    logic [3:0] ch, off;
    logic [NUM_CH-1:0] n_start, n_clear, n_push;
    logic [DATA_W-1:0] n_dout;
    logic [3:0] eset, eclr;
    logic [2:0] st;
    int idx, clr_ch;
    ch = S_address[7:4];
    off = S_address[3:0];
    idx = int'(ch);
    n_start = '0; n_clear = '0; n_push = '0; n_dout = '0; eset = '0; eclr = '0;
    clr_ch = -1;
    if (S_sel && !S_wr) begin
      if (idx < NUM_CH) begin
        case (off)
          4'h2: n_dout = DATA_W'(m_ien[idx]);
          4'h3: n_dout = m_src[idx];
          4'h4: n_dout = m_dst[idx];
          4'h6: n_dout = DATA_W'(data_count[idx*DCNT_W +: DCNT_W]);
          4'h7: n_dout = m_size[idx];
          4'h8: n_dout = m_mode[idx];
          4'h9: n_dout = DATA_W'(m_done[idx]);
          default: n_dout = '0;
        endcase
      end else if (idx == 15) begin
        if (off == 4'h0) n_dout = DATA_W'(m_ien & m_done);
        if (off == 4'h1 && ERR_EN) n_dout = DATA_W'(m_err);
      end
    end
    if (S_sel && idx >= NUM_CH && idx != 15) eset[0] = 1'b1;
    if (S_sel && S_wr && idx < NUM_CH) begin
      st = state[idx*3 +: 3];
      case (off)
        4'h0: if (S_din[0] && m_done[idx]) begin n_clear[idx] = 1'b1; clr_ch = idx; end
        4'h1: if (S_din[0]) begin
                if (st == 3'd0) n_start[idx] = 1'b1; else eset[2] = 1'b1;
              end
        4'h5: if (S_din[0]) begin
                if (!desc_full[idx]) n_push[idx] = 1'b1; else eset[1] = 1'b1;
              end
        4'h2, 4'h3, 4'h4, 4'h7, 4'h8: begin
          if (st >= 3'd1 && st <= 3'd4) eset[3] = 1'b1;
          else case (off)
            4'h2: m_ien[idx] = S_din[0];
            4'h3: m_src[idx] = S_din;
            4'h4: m_dst[idx] = S_din;
            4'h7: m_size[idx] = S_din;
            default: m_mode[idx] = S_din;
          endcase
        end
        default: ;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++)
      m_done[c] = (c == clr_ch) ? 1'b0 : (m_done[c] | op_done[c]);
    if (clr_ch >= 0) begin
      m_src[clr_ch] = '0; m_dst[clr_ch] = '0; m_size[clr_ch] = '0;
      m_mode[clr_ch] = '0; m_ien[clr_ch] = 1'b0;
    end
    if (S_sel && S_wr && idx == 15 && off == 4'h1) eclr = S_din[3:0];
    if (ERR_EN) m_err = (m_err & ~eclr) | eset;
    m_start = n_start; m_clear = n_clear; m_push = n_push; m_dout = n_dout;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [127:0] e_sc, e_ds, e_sz, e_om;
  logic         e_int;

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        e_int = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          e_sc[c*32 +: 32] = m_src[c];
          e_ds[c*32 +: 32] = m_dst[c];
          e_sz[c*32 +: 32] = m_size[c];
          e_om[c*32 +: 32] = m_mode[c];
          e_int = e_int | (m_ien[c] & m_done[c]);
        end
        check("op_start", op_start, m_start);
        check("op_clear", op_clear, m_clear);
        check("wr_en", wr_en, m_push);
        check("sc_addr", sc_addr, e_sc);
        check("ds_addr", ds_addr, e_ds);
        check("data_size", data_size, e_sz);
        check("opmode", opmode, e_om);
        check("S_dout", S_dout, m_dout);
        check("Interrupt", Interrupt, e_int);
        check("err_irq", err_irq, |m_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
  endtask

  task automatic bus_write(input logic [3:0] ch, input logic [3:0] off, input logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b1; S_address = {ch, off}; S_din = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_read(input logic [3:0] ch, input logic [3:0] off, output logic [31:0] d);
    S_sel = 1'b1; S_wr = 1'b0; S_address = {ch, off}; S_din = '0;
    @(negedge clk);
    d = S_dout;
    idle_bus();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic [31:0] din_r;
  int          r;

  initial begin
    reset_n = 1'b0;
    idle_bus();
    state = '0; op_done = '0; desc_full = '0; data_count = '0;
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset S_dout", S_dout, 0);
    check("reset op_start", op_start, 0);
    check("reset sc_addr", sc_addr, 0);
    check("reset Interrupt", Interrupt, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ch1 config write / readback
    bus_write(4'd1, 4'h3, 32'h100);
    bus_write(4'd1, 4'h4, 32'h200);
    bus_write(4'd1, 4'h7, 32'h10);
    bus_read(4'd1, 4'h3, rd); check("ch1 SRC read", rd, 32'h100);
    bus_read(4'd1, 4'h4, rd); check("ch1 DST read", rd, 32'h200);
    bus_read(4'd1, 4'h7, rd); check("ch1 SIZE read", rd, 32'h10);
    check("ch0 SRC zero", sc_addr[31:0], 0);
    check("ch1 sc_addr", sc_addr[63:32], 32'h100);
    check("ch0 DST zero", ds_addr[31:0], 0);

    // asynchronous reset during a READ-state transfer
    state[2:0] = 3'd3;
    S_sel = 1'b1; S_wr = 1'b0; S_address = {4'd1, 4'h3};
    @(posedge clk);
    #2;
    check("pre-reset S_dout", S_dout, 32'h100);
    reset_n = 1'b0;
    #1;
    check("async S_dout", S_dout, 0);
    check("async sc_addr", sc_addr, 0);
    check("async ds_addr", ds_addr, 0);
    check("async data_size", data_size, 0);
    check("async Interrupt", Interrupt, 0);
    idle_bus();
    state = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ch2 start, then start while READ
    bus_write(4'd2, 4'h1, 32'h1);
    check("ch2 start pulse", op_start, 4'b0100);
    @(negedge clk);
    check("ch2 start one cycle", op_start, 4'b0000);
    state[8:6] = 3'd3;
    bus_write(4'd2, 4'h1, 32'h1);
    check("start while READ", op_start, 4'b0000);
    bus_read(4'hF, 4'h1, rd);
    check("ERR after busy start", rd, ERR_EN ? 32'h4 : 32'h0);
    bus_write(4'hF, 4'h1, 32'hF);
    state[8:6] = 3'd0;

    // ch0 interrupt and clear
    bus_write(4'd0, 4'h2, 32'h1);
    bus_write(4'd0, 4'h3, 32'h55);
    bus_write(4'd0, 4'h4, 32'h66);
    bus_write(4'd0, 4'h7, 32'h77);
    op_done[0] = 1'b1;
    @(negedge clk);
    op_done[0] = 1'b0;
    check("Interrupt after done", Interrupt, 1);
    bus_read(4'hF, 4'h0, rd);
    check("IRQ_STAT", rd, 32'h1);
    bus_write(4'd0, 4'h0, 32'h1);
    check("op_clear pulse", op_clear, 4'b0001);
    check("Interrupt after clear", Interrupt, 0);
    check("ch0 SRC cleared", sc_addr[31:0], 0);
    check("ch0 DST cleared", ds_addr[31:0], 0);
    check("ch0 SIZE cleared", data_size[31:0], 0);
    @(negedge clk);
    check("op_clear one cycle", op_clear, 4'b0000);

    // ch3 push with/without full, DCNT
    desc_full[3] = 1'b1;
    bus_write(4'd3, 4'h5, 32'h1);
    check("push while full", wr_en, 4'b0000);
    desc_full[3] = 1'b0;
    bus_write(4'd3, 4'h5, 32'h1);
    check("push", wr_en, 4'b1000);
    data_count[15:12] = 4'd5;
    bus_read(4'd3, 4'h6, rd);
    check("DCNT", rd, 32'h5);
    bus_write(4'hF, 4'h1, 32'hF);

    // unmapped channel
    bus_write(4'd6, 4'h3, 32'h123);
    check("unmapped write ignored", sc_addr, 0);
    check("err_irq after unmapped", err_irq, ERR_EN);
    bus_read(4'hF, 4'h1, rd);
    check("ERR unmapped bit", rd, ERR_EN ? 32'h1 : 32'h0);
    bus_write(4'hF, 4'h1, 32'h1);
    check("err_irq after W1C", err_irq, 0);

    // random traffic
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 8 == 0) begin
        for (int c = 0; c < NUM_CH; c++)
          state[c*3 +: 3] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        op_done[c]   = ($urandom_range(0, 7) == 0);
        desc_full[c] = ($urandom_range(0, 2) == 0);
      end
      data_count = 16'($urandom);
      r = $urandom_range(0, 9);
      din_r = $urandom;
      if ($urandom_range(0, 3) != 0) din_r[0] = 1'b1;
      S_sel = ($urandom_range(0, 3) != 0);
      S_wr  = $urandom_range(0, 1);
      S_din = din_r;
      if (r <= 6)      S_address[7:4] = 4'(r % NUM_CH);
      else if (r <= 8) S_address[7:4] = 4'hF;
      else             S_address[7:4] = 4'($urandom_range(4, 14));
      S_address[3:0] = 4'($urandom_range(0, 10));
      @(negedge clk);
    end
    idle_bus();
    op_done = '0;
    repeat (3) @(negedge clk);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
